// File: rtl/pie_demodulator_mc_if.sv
// Output word channel of the PIE demodulator: data, parity flag and
// a valid/ready handshake. The demodulator drives it through the master modport.
interface pie_demodulator_mc_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_perr;

  modport master (output out_data, output out_valid, output out_perr, input out_ready);
  modport slave  (input out_data, input out_valid, input out_perr, output out_ready);
endinterface

// File: rtl/pie_demodulator_mc.sv
// Pulse-interval demodulator: synchronises the envelope bit, measures intervals
// between rising edges, hunts for a preamble and then assembles words that are
// handed out over a valid/ready channel. Two timing schemes are selectable per frame.
// Optional even-parity symbol after each word: define PIE_DEMOD_PARITY_EN.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for a rising edge to open a frame
// ST_SYNC | shifting bits through the preamble window
// ST_DATA | assembling words, delimiter or timeout closes the frame
module pie_demodulator_mc #(
  parameter int               SYNC_STAGES = 2,
  parameter int               CNT_W       = 10,
  parameter int               WORD_W      = 8,
  parameter int               PRE_W       = 8,
  parameter logic [PRE_W-1:0] PREAMBLE    = 8'hB3,
  parameter int               MIN0        = 4,
  parameter int               SPLIT0      = 15,
  parameter int               MAX0        = 30,
  parameter int               MIN1        = 8,
  parameter int               SPLIT1      = 31,
  parameter int               MAX1        = 62,
  parameter int               TIMEOUT     = 255
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  input  logic                insig_i,
  input  logic                working_i,
  input  logic                scheme_i,
  pie_demodulator_mc_if.master out_if,
  output logic [7:0]          frame_cnt_o,
  output logic                cur_flag_o,
  output logic                cur_scheme_o,
  output logic                frame_end_o,
  output logic                overrun_o
);

`ifdef PIE_DEMOD_PARITY_EN
  localparam int LAST_BIT = WORD_W;
`else
  localparam int LAST_BIT = WORD_W - 1;
`endif
  localparam int BC_W = $clog2(WORD_W + 2);
  localparam int PC_W = $clog2(PRE_W + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA} state_t;

  state_t             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               prev_q, rise_q;
  logic [CNT_W-1:0]   cnt_q, min_v, split_v, max_v;
  logic               glitch, bit_val, delim, timeout_hit, edge_ok;
  logic               start, term, bit_ev, word_done, pre_hit, slot_free, perr_next;
  logic [PRE_W-1:0]   pre_q, pre_next;
  logic [PC_W-1:0]    pre_cnt_q;
  logic [WORD_W-1:0]  word_q, word_full, data_q;
  logic [BC_W-1:0]    bit_cnt_q;
  logic [7:0]         frame_cnt_q;
  logic               cur_scheme_q, frame_end_q, overrun_q, valid_q, perr_q;

  // Metastability chain plus a registered rising-edge strobe.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], insig_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign min_v       = cur_scheme_q ? CNT_W'(MIN1)   : CNT_W'(MIN0);
  assign split_v     = cur_scheme_q ? CNT_W'(SPLIT1) : CNT_W'(SPLIT0);
  assign max_v       = cur_scheme_q ? CNT_W'(MAX1)   : CNT_W'(MAX0);
  assign glitch      = cnt_q < min_v;
  assign bit_val     = cnt_q > split_v;
  assign delim       = cnt_q > max_v;
  assign timeout_hit = cnt_q == CNT_W'(TIMEOUT);
  // Any edge opens a frame from IDLE; inside a frame short intervals are dropped.
  assign edge_ok     = rise_q & ((state_q == ST_IDLE) | ~glitch);
  assign pre_next    = {pre_q[PRE_W-2:0], bit_val};
  assign pre_hit     = (pre_cnt_q >= PC_W'(PRE_W - 1)) && (pre_next == PREAMBLE);
  assign word_done   = bit_ev && (state_q == ST_DATA) && (bit_cnt_q == BC_W'(LAST_BIT));
  assign slot_free   = ~valid_q | out_if.out_ready;

  // Interval counter: restarts on accepted edges, saturates otherwise.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i)            cnt_q <= '0;
    else if (edge_ok)          cnt_q <= CNT_W'(1);
    else if (cnt_q != '1)      cnt_q <= cnt_q + CNT_W'(1);
  end

  // State register.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    term    = 1'b0;
    bit_ev  = 1'b0;
    if (!working_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (rise_q) begin
          start   = 1'b1;
          state_d = ST_SYNC;
        end
        ST_SYNC, ST_DATA: begin
          if ((edge_ok && delim) || timeout_hit) begin
            term    = 1'b1;
            state_d = ST_IDLE;
          end else if (edge_ok) begin
            bit_ev = 1'b1;
            if (state_q == ST_SYNC && pre_hit) state_d = ST_DATA;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Per-frame context: latched scheme, word count, preamble window.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cur_scheme_q <= 1'b0;
      frame_cnt_q  <= '0;
      pre_q        <= '0;
      pre_cnt_q    <= '0;
    end else if (start) begin
      cur_scheme_q <= scheme_i;
      frame_cnt_q  <= '0;
      pre_q        <= '0;
      pre_cnt_q    <= '0;
    end else begin
      if (bit_ev && state_q == ST_SYNC) begin
        pre_q <= pre_next;
        if (pre_cnt_q != PC_W'(PRE_W)) pre_cnt_q <= pre_cnt_q + PC_W'(1);
      end
      if (word_done && slot_free && frame_cnt_q != 8'hFF) frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  // Word shift register and bit position; anything partial is forgotten outside DATA.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      word_q    <= '0;
      bit_cnt_q <= '0;
    end else if (state_q != ST_DATA) begin
      bit_cnt_q <= '0;
    end else if (bit_ev) begin
      bit_cnt_q <= word_done ? '0 : bit_cnt_q + BC_W'(1);
      if (bit_cnt_q < BC_W'(WORD_W)) word_q <= {word_q[WORD_W-2:0], bit_val};
    end
  end

`ifdef PIE_DEMOD_PARITY_EN
  logic par_q;

  // Running parity over the data bits of the current word.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i)                         par_q <= 1'b0;
    else if (state_q != ST_DATA || word_done) par_q <= 1'b0;
    else if (bit_ev)                        par_q <= par_q ^ bit_val;
  end

  assign word_full = word_q;
  assign perr_next = par_q ^ bit_val;
`else
  assign word_full = {word_q[WORD_W-2:0], bit_val};
  assign perr_next = 1'b0;
`endif

  // Output holding register, handshake and sticky overrun.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_q      <= '0;
      perr_q      <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      frame_end_q <= term;
      if (word_done && slot_free) begin
        data_q  <= word_full;
        perr_q  <= perr_next;
        valid_q <= 1'b1;
      end else begin
        if (word_done)                   overrun_q <= 1'b1;
        if (valid_q && out_if.out_ready) valid_q   <= 1'b0;
      end
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_perr  = perr_q;
  assign frame_cnt_o      = frame_cnt_q;
  assign cur_flag_o       = (state_q != ST_IDLE);
  assign cur_scheme_o     = cur_scheme_q;
  assign frame_end_o      = frame_end_q;
  assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_pie_demodulator_mc.sv
// Randomised bench for pie_demodulator_mc with a bit-level reference model
// feeding a scoreboard that is drained by an independent output monitor.
module tb_pie_demodulator_mc;
  localparam int S = 2;
  localparam logic [7:0] PRE = 8'hB3;
  localparam int MIN0 = 4, SPLIT0 = 15, MAX0 = 30;
  localparam int MIN1 = 8, SPLIT1 = 31, MAX1 = 62;
`ifdef PIE_DEMOD_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, insig = 1'b0, working = 1'b0, scheme = 1'b0;
  logic [7:0] frame_cnt;
  logic cur_flag, cur_scheme, frame_end, overrun;

  pie_demodulator_mc_if #(.WORD_W(8)) bus ();

  pie_demodulator_mc dut (
    .clock_i     (clk),
    .reset_n_i   (rst_n),
    .insig_i     (insig),
    .working_i   (working),
    .scheme_i    (scheme),
    .out_if      (bus.master),
    .frame_cnt_o (frame_cnt),
    .cur_flag_o  (cur_flag),
    .cur_scheme_o(cur_scheme),
    .frame_end_o (frame_end),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, fe_cnt = 0;
  bit rand_ready = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  bit tx[$];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Monitor: count frame_end pulses, match every accepted word against the scoreboard.
  always @(negedge clk) begin
    if (frame_end === 1'b1) fe_cnt++;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      check("word_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("word_data", bus.out_data, mon_e[7:0]);
        check("word_perr", bus.out_perr, mon_e[8]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic pulse(input int g, input bit gl);
    insig = 1'b1; tick(2); insig = 1'b0;
    if (gl) begin
      tick(1); insig = 1'b1; tick(2); insig = 1'b0; tick(g - 5);
    end else tick(g - 2);
  endtask

  function automatic int gap_for(input bit b, input bit sch);
    int lo, hi, r;
    if (!b) begin lo = sch ? MIN1 : MIN0;          hi = sch ? SPLIT1 : SPLIT0; end
    else    begin lo = (sch ? SPLIT1 : SPLIT0) + 1; hi = sch ? MAX1 : MAX0;     end
    r = $urandom_range(0, 3);
    return (r == 0) ? lo : (r == 1) ? hi : $urandom_range(lo, hi);
  endfunction

  // gmode: 0 no glitches, 1 glitch in every long enough interval, 2 random
  task automatic send_tx(input int from, input int to, input bit sch, input int i0, input int i1,
                         input int gmode);
    int g;
    bit gl;
    for (int k = from; k < to; k++) begin
      g  = (i0 != 0) ? (tx[k] ? i1 : i0) : gap_for(tx[k], sch);
      gl = (g >= 6) && (gmode == 1 || (gmode == 2 && $urandom_range(0, 1) == 1));
      pulse(g, gl);
    end
  endtask

  task automatic add_pre();
    logic [7:0] p = PRE;
    for (int i = 7; i >= 0; i--) tx.push_back(p[i]);
  endtask

  task automatic add_word(input logic [7:0] w, input bit bad);
    for (int i = 7; i >= 0; i--) tx.push_back(w[i]);
    if (PAR) tx.push_back((^w) ^ bad);
  endtask

  task automatic add_bits(input int n);
    for (int i = 0; i < n; i++) tx.push_back(1'($urandom_range(0, 1)));
  endtask

  // Reference: first preamble match in the bit stream, then whole words only.
  function automatic int model_push();
    int found = -1, n = 0;
    int chunk = PAR ? 9 : 8;
    logic [7:0] sh = '0;
    for (int k = 0; k < tx.size(); k++) begin
      sh = {sh[6:0], tx[k]};
      if (k >= 7 && sh == PRE) begin found = k; break; end
    end
    if (found >= 0) begin
      for (int p = found + 1; p + chunk <= tx.size(); p += chunk) begin
        logic [7:0] w = '0;
        logic pe = 1'b0;
        for (int i = 0; i < chunk; i++) begin
          if (i < 8) w = {w[6:0], tx[p + i]};
          pe ^= tx[p + i];
        end
        exp_q.push_back({PAR ? pe : 1'b0, w});
        n++;
      end
    end
    return n;
  endfunction

  task automatic close_delim(input bit sch);
    pulse((sch ? MAX1 : MAX0) + 1 + $urandom_range(0, 15), 1'b0);
    pulse(10, 1'b0);
  endtask

  int n, fe0, last_n;
  bit sch, use_to;

  initial begin
    bus.out_ready = 1'b0;
    tick(3);
    check("rst_data", bus.out_data, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_perr", bus.out_perr, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_cur_flag", cur_flag, 0);
    check("rst_frame_end", frame_end, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1; working = 1'b1; bus.out_ready = 1'b1;
    tick(5);

    // Scheme 0 with 10/20 intervals, latency of the final word bit.
    tx.delete(); add_pre(); add_word(8'h5A, 1'b0);
    scheme = 1'b0; n = model_push(); fe0 = fe_cnt;
    send_tx(0, 8, 1'b0, 10, 20, 0);
    check("t1_cur_flag", cur_flag, 1);
    check("t1_cur_scheme", cur_scheme, 0);
    send_tx(8, tx.size(), 1'b0, 10, 20, 0);
    insig = 1'b1;
    for (int i = 1; i <= S + 2; i++) begin
      tick(1);
      if (i == 2) insig = 1'b0;
      if (i == S + 1) check("t1_lat_early", bus.out_valid, 0);
    end
    check("t1_lat_valid", bus.out_valid, 1);
    check("t1_frame_cnt", frame_cnt, 1);
    tick(40 - S - 2); pulse(10, 1'b0); tick(5);
    check("t1_frame_end", fe_cnt - fe0, 1);
    check("t1_flag_clear", cur_flag, 0);
    check("t1_drained", exp_q.size(), 0);

    // Scheme 1 with scheme input flipped after the preamble.
    tx.delete(); add_pre(); add_word(8'h5A, 1'b0);
    scheme = 1'b1; n = model_push();
    send_tx(0, 8, 1'b1, 20, 45, 0);
    scheme = 1'b0;
    send_tx(8, tx.size(), 1'b1, 20, 45, 0);
    check("t2_cur_scheme", cur_scheme, 1);
    close_delim(1'b1); tick(5);
    check("t2_frame_cnt", frame_cnt, 1);
    check("t2_drained", exp_q.size(), 0);

    // Glitch pulses inside intervals.
    tx.delete(); add_pre(); add_word(8'h5A, 1'b0); add_word(8'h3C, 1'b0);
    n = model_push();
    send_tx(0, tx.size(), 1'b0, 10, 20, 1);
    close_delim(1'b0); tick(5);
    check("t3_frame_cnt", frame_cnt, 2);
    check("t3_drained", exp_q.size(), 0);

    // Randomised frames with random backpressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      sch = 1'($urandom_range(0, 1)); use_to = ($urandom_range(0, 2) == 0);
      tx.delete(); add_bits($urandom_range(0, 4)); add_pre();
      for (int w = 0; w < $urandom_range(1, 3); w++)
        add_word(8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
      scheme = sch; n = model_push(); fe0 = fe_cnt;
      send_tx(0, tx.size(), sch, 0, 0, 2);
      if (use_to) begin insig = 1'b1; tick(2); insig = 1'b0; tick(300); end
      else close_delim(sch);
      tick(5);
      check("rnd_frame_cnt", frame_cnt, n);
      check("rnd_frame_end", fe_cnt - fe0, 1);
      check("rnd_drained", exp_q.size(), 0);
    end
    rand_ready = 1'b0; bus.out_ready = 1'b1; tick(3);
    check("rnd_no_overrun", overrun, 0);

    // Backpressure across two words: second word is dropped.
    bus.out_ready = 1'b0; scheme = 1'b0;
    tx.delete(); add_pre(); add_word(8'hA1, 1'b0); add_word(8'hC3, 1'b0);
    exp_q.push_back({1'b0, 8'hA1});
    send_tx(0, tx.size(), 1'b0, 0, 0, 0);
    insig = 1'b1; tick(2); insig = 1'b0; tick(10);
    check("t4_valid_held", bus.out_valid, 1);
    check("t4_data_held", bus.out_data, 8'hA1);
    check("t4_overrun", overrun, 1);
    check("t4_frame_cnt", frame_cnt, 1);
    bus.out_ready = 1'b1; tick(2);
    check("t4_valid_clear", bus.out_valid, 0);
    check("t4_drained", exp_q.size(), 0);
    tick(300);

    // Delimiter mid-word, then timeout mid-word.
    tx.delete(); add_pre(); add_bits(4);
    last_n = model_push(); fe0 = fe_cnt;
    send_tx(0, tx.size(), 1'b0, 0, 0, 0);
    close_delim(1'b0); tick(5);
    check("t5_delim_fe", fe_cnt - fe0, 1);
    check("t5_delim_flag", cur_flag, 0);
    check("t5_delim_cnt", frame_cnt, 0);
    check("t5_delim_words", exp_q.size(), 0);
    tx.delete(); add_pre(); add_bits(3);
    last_n = model_push(); fe0 = fe_cnt;
    send_tx(0, tx.size(), 1'b0, 0, 0, 0);
    insig = 1'b1; tick(2); insig = 1'b0; tick(200);
    check("t5_to_still_open", cur_flag, 1);
    tick(100);
    check("t5_to_fe", fe_cnt - fe0, 1);
    check("t5_to_flag", cur_flag, 0);
    check("t5_to_cnt", frame_cnt, 0);

    // working dropped mid-frame: IDLE without frame_end.
    tx.delete(); add_pre(); add_bits(3);
    send_tx(0, tx.size(), 1'b0, 0, 0, 0);
    check("t6_open", cur_flag, 1);
    fe0 = fe_cnt; working = 1'b0; tick(2);
    check("t6_work_flag", cur_flag, 0);
    tick(3);
    check("t6_work_no_fe", fe_cnt - fe0, 0);
    working = 1'b1; tick(5);

    // Reset mid-word with a pending word and sticky overrun.
    bus.out_ready = 1'b0; scheme = 1'b1;
    tx.delete(); add_pre(); add_word(8'h96, 1'b0); add_bits(4);
    send_tx(0, tx.size(), 1'b1, 0, 0, 0);
    tick(5);
    check("t6_pre_rst_valid", bus.out_valid, 1);
    check("t6_pre_rst_scheme", cur_scheme, 1);
    check("t6_overrun_sticky", overrun, 1);
    rst_n = 1'b0; tick(1);
    check("t6_rst_data", bus.out_data, 0);
    check("t6_rst_valid", bus.out_valid, 0);
    check("t6_rst_perr", bus.out_perr, 0);
    check("t6_rst_cnt", frame_cnt, 0);
    check("t6_rst_flag", cur_flag, 0);
    check("t6_rst_scheme", cur_scheme, 0);
    check("t6_rst_overrun", overrun, 0);
    rst_n = 1'b1; bus.out_ready = 1'b1; scheme = 1'b0; tick(5);

    // Word with a corrupted parity symbol (plain word without parity build).
    tx.delete(); add_pre(); add_word(8'h5A, 1'b1);
    n = model_push();
    send_tx(0, tx.size(), 1'b0, 0, 0, 0);
    close_delim(1'b0); tick(5);
    check("t6_par_drained", exp_q.size(), 0);
    check("t6_par_cnt", frame_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pie_demodulator_mc.md
Name: pie_demodulator_mc

Overview:
Parametrised successor of the single-mode backscatter demodulator. It takes the 1-bit envelope-detected tag signal and decodes pulse-interval symbols into bits. It hunts for a configurable preamble, then assembles fixed-width words and delivers them over a valid/ready interface. It supports two run-time-selectable timing schemes, frame tracking, timeout and overrun reporting. It sits between the envelope comparator input and the codeword-translation logic.

Parameters:
SYNC_STAGES, 2, input synchroniser depth (>=2)
CNT_W, 10, interval counter width
WORD_W, 8, output word width
PRE_W, 8, preamble length in bits
PREAMBLE, 8'hB3, preamble pattern, first-received bit in MSB
MIN0, 4, scheme 0: intervals < MIN0 are glitches
SPLIT0, 15, scheme 0: MIN0..SPLIT0 = bit 0
MAX0, 30, scheme 0: SPLIT0+1..MAX0 = bit 1; > MAX0 = delimiter
MIN1, 8, scheme 1 glitch bound
SPLIT1, 31, scheme 1 bit-0/bit-1 split
MAX1, 62, scheme 1 delimiter bound
TIMEOUT, 255, cycles without a rising edge before frame abort (< 2^CNT_W)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
insig  in  1  raw envelope bit, asynchronous to clock
working  in  1  demodulator enable; 0 forces IDLE
scheme  in  1  timing-scheme select, sampled at frame start
out_ready  in  1  downstream accepts word
out_data  out  WORD_W  decoded word, first bit in MSB
out_valid  out  1  word available
out_perr  out  1  parity error on out_data (see optional feature)
frame_cnt  out  8  words delivered in current frame, saturating at 255
cur_flag  out  1  high while in SYNC or DATA
cur_scheme  out  1  scheme latched for current frame
frame_end  out  1  one-cycle pulse on frame termination
overrun  out  1  sticky; word dropped because previous word was not accepted

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, overrun cleared. Reset is also the only clear for overrun.
- insig passes through a SYNC_STAGES flop chain. A rising edge is detected by comparing the last stage with one extra flop.
- Interval counter: loads 1 on a valid rising edge and increments each cycle, saturating at 2^CNT_W-1. On the next rising edge, len = counter value.
- Classification uses the latched scheme:
  - len < MIN: glitch. The edge is ignored and the counter is not reloaded.
  - len <= SPLIT: bit 0.
  - len <= MAX: bit 1.
  - len > MAX: delimiter.
- IDLE: on a rising edge with working=1, latch scheme into cur_scheme, load the counter, clear frame_cnt and go to SYNC. cur_flag is high from the next cycle.
- SYNC: shift each bit into a PRE_W register (sliding). Once at least PRE_W bits are received and the register equals PREAMBLE, go to DATA.
- DATA: shift bits into a WORD_W register. On the WORD_W-th bit:
  - If out_valid=0 or out_ready=1 in that cycle, load out_data and assert out_valid on the next cycle, and increment frame_cnt.
  - Otherwise drop the word and set overrun.
  - The bit counter then restarts.
- Handshake: a transfer completes on any cycle with out_valid & out_ready. out_valid and out_data stay stable until accepted. Acceptance may occur while a new word completes in the same cycle (back-to-back).
- Frame termination, from SYNC or DATA:
  - A delimiter or counter == TIMEOUT moves to IDLE, pulses frame_end for one cycle and clears cur_flag. A partial word is discarded.
  - A pending out_valid word is retained until accepted.
- A delimiter in IDLE is ignored.
- working=0 sends any state to IDLE on the next clock, with no frame_end pulse. Pending output is retained and the handshake continues.
- scheme changes mid-frame have no effect until the next IDLE->SYNC transition.
- Latency: a raw insig rising edge completing the last word bit gives out_valid high SYNC_STAGES+2 clocks later.

Optional Feature:
- Macro: PIE_DEMOD_PARITY_EN.
- When defined:
  - Each word in DATA is followed by one even-parity symbol.
  - The word is presented after the parity bit.
  - out_perr = 1 when the parity over word+parity bit is odd, with the same timing as out_data.
- When undefined:
  - No parity symbol; the word is presented after its WORD_W-th bit.
  - out_perr is constant 0.

Test Plan:
1. Reset, then working=1, scheme=0. Send a start edge, preamble B3 (interval 10 = 0, 20 = 1), then data 5A. -> cur_flag=1; out_valid with out_data=8'h5A; frame_cnt=1; cur_scheme=0.
2. Same frame with scheme=1 intervals (20/45). Toggle scheme to 0 after the preamble. -> out_data=5A decoded correctly; cur_scheme stays 1.
3. Insert 2-cycle glitch pulses inside interval-20 bits. -> glitches ignored; words unchanged; no extra frame_cnt.
4. Hold out_ready=0 across two complete words (A1, C3). -> out_data stays A1; overrun=1; after out_ready=1, A1 is accepted and C3 never appears.
5. Mid-word, send an interval of 40 (scheme 0), then separately stop edges for 256 cycles. -> frame_end pulses once each time; cur_flag=0; partial word discarded; frame_cnt unchanged.
6. Drop working mid-frame; assert reset mid-word; with PIE_DEMOD_PARITY_EN, send 5A with a wrong parity bit. -> IDLE with no frame_end; all outputs 0 after reset; out_perr=1 with out_data=5A.
